// File: rtl/rr_arbiter_pkg.sv
// Shared types for the round-robin arbiter: FSM state encoding and counter sizing.
// No logic or timing of its own.
package rr_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } arb_state_t;

  // The hold counter must represent max_hold itself, and is never narrower than one bit.
  function automatic int hold_width(input int max_hold);
    int w;
    w = $clog2(max_hold + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/demux.sv
// One-hot decoder: drives bit `selector` of dout when enable is high, all zero otherwise.
// Purely combinational, zero latency, no flow control.
module demux #(
  parameter  int OUTPUT_WIDTH = 4,
  localparam int SEL_W        = (OUTPUT_WIDTH > 1) ? $clog2(OUTPUT_WIDTH) : 1
) (
  input  logic                    enable,
  input  logic [SEL_W-1:0]        selector,
  output logic [OUTPUT_WIDTH-1:0] dout
);

  always_comb begin
    dout = '0;
    if (enable) dout[selector] = 1'b1;
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter for one shared resource; grant appears one cycle after a request is sampled in IDLE.
// Owners hold until they drop req or MAX_HOLD expires; one RELEASE plus one IDLE cycle separates owners.
module rr_arbiter
  import rr_arbiter_pkg::*;
#(
  parameter  int REQUESTERS = 4,
  parameter  int MAX_HOLD   = 16,
  localparam int SEL_W      = $clog2(REQUESTERS),
  localparam int HOLD_W     = hold_width(MAX_HOLD)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REQUESTERS-1:0] req,
  output logic [REQUESTERS-1:0] grant,
  output logic                  grant_valid,
  output logic [SEL_W-1:0]      grant_index,
  output logic                  preempted
);

  arb_state_t        state_q, state_d;
  logic [SEL_W-1:0]  idx_q, idx_d;
  logic [SEL_W-1:0]  last_q, last_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              pre_q, pre_d;

  logic [SEL_W-1:0]  pick;
  logic [SEL_W-1:0]  cand;
  logic              pick_vld;
  logic              owner_req;
  logic              expire;

  // Walk from the farthest slot towards last+1 so the nearest requester is assigned last and wins.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    cand     = '0;
    for (int i = REQUESTERS; i >= 1; i--) begin
      cand = SEL_W'((int'(last_q) + i) % REQUESTERS);
      if (req[cand]) begin
        pick     = cand;
        pick_vld = 1'b1;
      end
    end
  end

  assign owner_req = req[idx_q];
  assign expire    = (MAX_HOLD != 0) && ((int'(hold_q) + 1) >= MAX_HOLD);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    last_d  = last_q;
    hold_d  = hold_q;
    pre_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          state_d = ST_GRANT;
          idx_d   = pick;
          hold_d  = '0;
        end
      end
      ST_GRANT: begin
        hold_d = (hold_q == {HOLD_W{1'b1}}) ? hold_q : hold_q + HOLD_W'(1);
        // A voluntary release takes precedence, so a coincident expiry does not pulse preempted.
        if (!owner_req) begin
          state_d = ST_RELEASE;
        end else if (expire) begin
          state_d = ST_RELEASE;
          pre_d   = 1'b1;
        end
      end
      ST_RELEASE: begin
        last_d  = idx_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      last_q  <= SEL_W'(REQUESTERS - 1);
      hold_q  <= '0;
      pre_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
      pre_q   <= pre_d;
    end
  end

  assign grant_valid = (state_q == ST_GRANT);
  assign grant_index = idx_q;
  assign preempted   = pre_q;

  demux #(
    .OUTPUT_WIDTH(REQUESTERS)
  ) u_grant_demux (
    .enable  (grant_valid),
    .selector(idx_q),
    .dout    (grant)
  );

endmodule

// File: tb/tb_rr_arbiter.sv
// Bench for rr_arbiter: hand-derived vector table for directed corners, then random requests against a model.
module tb_rr_arbiter;

  localparam int N    = 4;
  localparam int MAXH = 4;

  logic         clk;
  logic         rst;
  logic [N-1:0] req;
  logic [N-1:0] grant;
  logic         grant_valid;
  logic [1:0]   grant_index;
  logic         preempted;

  int n_vec;
  int n_bad;

  rr_arbiter #(
    .REQUESTERS(N),
    .MAX_HOLD  (MAXH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .grant      (grant),
    .grant_valid(grant_valid),
    .grant_index(grant_index),
    .preempted  (preempted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string        tag;
    logic         rn;
    logic [N-1:0] rq;
    int           n;
    logic [N-1:0] eg;
    logic         ep;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input string tag, input logic rn, input logic [N-1:0] rq, input int n,
                     input logic [N-1:0] eg, input logic ep);
    vec_t v;
    v.tag = tag; v.rn = rn; v.rq = rq; v.n = n; v.eg = eg; v.ep = ep;
    tbl.push_back(v);
  endtask

  task automatic check(input string tag, input logic [N-1:0] eg, input logic ep);
    logic       ev;
    logic [1:0] ei;
    logic       bad;
    ev = |eg;
    ei = '0;
    for (int i = 0; i < N; i++) if (eg[i]) ei = 2'(i);
    bad = (grant !== eg) || (grant_valid !== ev) || (preempted !== ep) ||
          (ev && (grant_index !== ei));
    n_vec++;
    if (bad) begin
      n_bad++;
      $display("FAIL %s @%0t: got grant=%b valid=%b idx=%0d pre=%b, want grant=%b valid=%b idx=%0d pre=%b",
               tag, $time, grant, grant_valid, grant_index, preempted, eg, ev, ei, ep);
    end
  endtask

  // Reference model: who owns the resource, how long they have held it, and how many
  // dead cycles remain before the next arbitration.
  int m_owner, m_held, m_gap, m_last;
  bit m_pre;

  task automatic model_step(input logic rn, input logic [N-1:0] r);
    if (!rn) begin
      m_owner = -1; m_held = 0; m_gap = 0; m_last = N - 1; m_pre = 0;
      return;
    end
    m_pre = 0;
    if (m_owner >= 0) begin
      m_held++;
      if (!r[m_owner]) begin
        m_last = m_owner; m_owner = -1; m_gap = 1;
      end else if (m_held == MAXH) begin
        m_last = m_owner; m_owner = -1; m_gap = 1; m_pre = 1;
      end
    end else if (m_gap > 0) begin
      m_gap--;
    end else begin
      for (int d = 1; d <= N; d++) begin
        if (r[(m_last + d) % N]) begin
          m_owner = (m_last + d) % N;
          m_held  = 0;
          break;
        end
      end
    end
  endtask

  initial begin
    logic [N-1:0] rq;
    logic         rn;
    logic [N-1:0] eg;
    n_vec = 0;
    n_bad = 0;
    rst   = 1'b0;
    req   = '0;

    add("reset",       1'b0, 4'b0000,  2, 4'b0000, 1'b0);
    add("idle",        1'b1, 4'b0000, 10, 4'b0000, 1'b0);
    add("single_gnt",  1'b1, 4'b0100,  1, 4'b0100, 1'b0);
    add("single_drop", 1'b1, 4'b0000,  2, 4'b0000, 1'b0);
    add("fair_reset",  1'b0, 4'b0000,  1, 4'b0000, 1'b0);
    for (int k = 0; k < N; k++) begin
      add("fair_hold", 1'b1, 4'b1111,                 3, 4'(1 << k), 1'b0);
      add("fair_drop", 1'b1, 4'b1111 & ~4'(1 << k),   1, 4'b0000,    1'b0);
      add("fair_gap",  1'b1, 4'b1111,                 1, 4'b0000,    1'b0);
    end
    add("fair_wrap",   1'b1, 4'b1111,  1, 4'b0001, 1'b0);
    add("fair_end",    1'b1, 4'b0000,  2, 4'b0000, 1'b0);
    add("exp_reset",   1'b0, 4'b0000,  1, 4'b0000, 1'b0);
    add("exp_hold0",   1'b1, 4'b0011,  4, 4'b0001, 1'b0);
    add("exp_pre0",    1'b1, 4'b0011,  1, 4'b0000, 1'b1);
    add("exp_gap0",    1'b1, 4'b0011,  1, 4'b0000, 1'b0);
    add("exp_hold1",   1'b1, 4'b0011,  4, 4'b0010, 1'b0);
    add("exp_pre1",    1'b1, 4'b0011,  1, 4'b0000, 1'b1);
    add("exp_gap1",    1'b1, 4'b0011,  1, 4'b0000, 1'b0);
    add("exp_back0",   1'b1, 4'b0011,  4, 4'b0001, 1'b0);
    add("sole_pre",    1'b1, 4'b0001,  1, 4'b0000, 1'b1);
    add("sole_gap",    1'b1, 4'b0001,  1, 4'b0000, 1'b0);
    add("sole_regnt",  1'b1, 4'b0001,  4, 4'b0001, 1'b0);
    add("sole_pre2",   1'b1, 4'b0001,  1, 4'b0000, 1'b1);
    add("sole_gap2",   1'b1, 4'b0001,  1, 4'b0000, 1'b0);
    add("simul_hold",  1'b1, 4'b0001,  4, 4'b0001, 1'b0);
    add("simul_rel",   1'b1, 4'b0000,  1, 4'b0000, 1'b0);
    add("simul_idle",  1'b1, 4'b0000,  1, 4'b0000, 1'b0);
    add("mid_gnt3",    1'b1, 4'b1000,  2, 4'b1000, 1'b0);
    add("mid_reset",   1'b0, 4'b1111,  2, 4'b0000, 1'b0);
    add("mid_after",   1'b1, 4'b1111,  1, 4'b0001, 1'b0);

    foreach (tbl[j]) begin
      for (int c = 0; c < tbl[j].n; c++) begin
        rst = tbl[j].rn;
        req = tbl[j].rq;
        @(posedge clk);
        #1;
        check(tbl[j].tag, tbl[j].eg, tbl[j].ep);
      end
    end

    rq = '0;
    for (int c = 0; c < 3000; c++) begin
      rn = (c < 2) ? 1'b0 : ($urandom_range(0, 199) != 0);
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 7) == 0) rq[b] = ~rq[b];
      rst = rn;
      req = rq;
      model_step(rn, rq);
      @(posedge clk);
      #1;
      eg = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
      check("random", eg, m_pre);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
